// File: rtl/eve_gene_collector.sv
// Gene collector: packs up to three valid child genes per cycle, in lane order, into a
// circular FIFO and drains one gene per cycle over valid/ready. Overflow and protocol flags are sticky.
module eve_gene_collector #(
  parameter int GENE_SZ = 64,
  parameter int DEPTH   = 16,
  parameter int ADDR_SZ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [GENE_SZ-1:0] gene_in1,
  input  logic [GENE_SZ-1:0] gene_in2,
  input  logic [GENE_SZ-1:0] gene_in3,
  input  logic [2:0]         in_valid,
  input  logic               genome_done,
  output logic [GENE_SZ-1:0] gene_out,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               stall,
  output logic [ADDR_SZ:0]   level,
  output logic               overflow,
  output logic               proto_err
);

  localparam int CW = ADDR_SZ + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [GENE_SZ:0]   mem_q [DEPTH];
  logic [GENE_SZ:0]   mem_d [DEPTH];
  logic [ADDR_SZ-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SZ-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               proto_err_q, proto_err_d;

  logic [GENE_SZ-1:0] lane [3];
  logic [GENE_SZ-1:0] pk_gene [3];
  logic [ADDR_SZ-1:0] wr_addr [3];
  logic [1:0]         n_in;
  logic [CW-1:0]      n_in_w;
  logic [CW-1:0]      free;
  logic               wr_en, drop, rd_en;

  assign lane[0] = gene_in1;
  assign lane[1] = gene_in2;
  assign lane[2] = gene_in3;

  // Compact valid lanes into consecutive slots, lowest lane first.
  always_comb begin
    n_in = '0;
    for (int k = 0; k < 3; k++) pk_gene[k] = '0;
    for (int i = 0; i < 3; i++) begin
      if (in_valid[i]) begin
        pk_gene[n_in] = lane[i];
        n_in          = n_in + 2'd1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) wr_addr[k] = wr_ptr_q + ADDR_SZ'(k);
  end

  assign n_in_w = CW'(n_in);
  assign free   = DEPTH_C - count_q;
  assign wr_en  = (n_in != 2'd0) && (n_in_w <= free);
  assign drop   = (n_in != 2'd0) && (n_in_w > free);
  assign rd_en  = out_valid && out_ready;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | drop;
    proto_err_d = proto_err_q | (genome_done && (in_valid == 3'b000));
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        // Only the final packed slot of a done burst carries the end-of-genome tag.
        for (int k = 0; k < 3; k++) begin
          if (2'(k) < n_in)
            mem_d[wr_addr[k]] = {genome_done && (2'(k) == n_in - 2'd1), pk_gene[k]};
        end
        wr_ptr_d = wr_ptr_q + ADDR_SZ'(n_in);
      end
      if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_SZ'(1);
      count_d = count_q + (wr_en ? n_in_w : '0) - (rd_en ? CW'(1) : '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < DEPTH; e++) mem_q[e] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign gene_out  = mem_q[rd_ptr_q][GENE_SZ-1:0];
  assign out_last  = mem_q[rd_ptr_q][GENE_SZ];
  assign out_valid = (count_q != '0);
  assign stall     = (free < CW'(3));
  assign level     = count_q;
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_eve_gene_collector.sv
// Bench for eve_gene_collector: queue-based reference model fed by the driver,
// with an independent monitor popping and comparing whatever the DUT presents.
module tb_eve_gene_collector;
  localparam int GENE_SZ = 64;
  localparam int DEPTH   = 16;
  localparam int ADDR_SZ = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               flush = 1'b0;
  logic [GENE_SZ-1:0] gene_in1 = '0, gene_in2 = '0, gene_in3 = '0;
  logic [2:0]         in_valid = '0;
  logic               genome_done = 1'b0;
  logic [GENE_SZ-1:0] gene_out;
  logic               out_last, out_valid;
  logic               out_ready = 1'b0;
  logic               stall;
  logic [ADDR_SZ:0]   level;
  logic               overflow, proto_err;

  typedef struct packed {
    logic               last;
    logic [GENE_SZ-1:0] gene;
  } ent_t;

  ent_t exp_q[$];
  bit   ovf_m  = 1'b0;
  bit   perr_m = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  eve_gene_collector #(.GENE_SZ(GENE_SZ), .DEPTH(DEPTH), .ADDR_SZ(ADDR_SZ)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .gene_in1(gene_in1), .gene_in2(gene_in2), .gene_in3(gene_in3),
    .in_valid(in_valid), .genome_done(genome_done),
    .gene_out(gene_out), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .stall(stall), .level(level), .overflow(overflow), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rg();
    return {$urandom, $urandom};
  endfunction

  // Monitor: mid-cycle, compare the presented head with the oldest expected gene.
  always @(negedge clk) begin
    if (rst) begin
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (out_valid && exp_q.size() > 0) begin
        chk("gene_out", gene_out, exp_q[0].gene);
        chk("out_last", 64'(out_last), 64'(exp_q[0].last));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; applies inputs, predicts the edge, checks status after it.
  task automatic cycle(input logic [2:0] v, input logic gd, input logic rdy, input logic fl,
                       input logic [63:0] g1, input logic [63:0] g2, input logic [63:0] g3);
    ent_t        pend[$];
    ent_t        e;
    logic [63:0] gl[3];
    int          n, fr, idx;
    gl[0] = g1; gl[1] = g2; gl[2] = g3;
    gene_in1 = g1; gene_in2 = g2; gene_in3 = g3;
    in_valid = v; genome_done = gd; out_ready = rdy; flush = fl;
    n  = $countones(v);
    fr = DEPTH - exp_q.size();
    if (n > fr) ovf_m = 1'b1;
    if (gd && n == 0) perr_m = 1'b1;
    if (!fl && n > 0 && n <= fr) begin
      idx = 0;
      for (int i = 0; i < 3; i++) begin
        if (v[i]) begin
          idx++;
          e.gene = gl[i];
          e.last = gd && (idx == n);
          pend.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    if (fl) exp_q.delete();
    else foreach (pend[j]) exp_q.push_back(pend[j]);
    chk("level", 64'(level), 64'(exp_q.size()));
    chk("stall", 64'(stall), 64'((DEPTH - exp_q.size()) < 3));
    chk("overflow", 64'(overflow), 64'(ovf_m));
    chk("proto_err", 64'(proto_err), 64'(perr_m));
  endtask

  task automatic idle(input logic rdy);
    cycle(3'b000, 1'b0, rdy, 1'b0, '0, '0, '0);
  endtask

  task automatic do_flush();
    cycle(3'b000, 1'b0, 1'b0, 1'b1, '0, '0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_level"}, 64'(level), 64'(0));
    chk({tag, "_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_stall"}, 64'(stall), 64'(0));
    chk({tag, "_ovf"}, 64'(overflow), 64'(0));
    chk({tag, "_perr"}, 64'(proto_err), 64'(0));
    chk({tag, "_gene"}, gene_out, 64'(0));
    chk({tag, "_last"}, 64'(out_last), 64'(0));
  endtask

  initial begin
    logic [2:0]  v;
    logic [63:0] g;
    // Reset state
    #12;
    check_reset_outputs("rst0");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single lane with genome_done
    cycle(3'b010, 1'b1, 1'b0, 1'b0, 64'h0, 64'hA5, 64'h0);
    chk("tp1_gene", gene_out, 64'hA5);
    chk("tp1_last", 64'(out_last), 64'(1));
    idle(1'b1);

    // Compaction and tag on the last lane only
    cycle(3'b101, 1'b0, 1'b0, 1'b0, 64'd1, 64'd2, 64'd3);
    cycle(3'b111, 1'b1, 1'b0, 1'b0, 64'd4, 64'd5, 64'd6);
    repeat (6) idle(1'b1);

    // Backpressure, then alternate ready with single genes to wrap pointers
    repeat (5) cycle(3'b111, 1'b0, 1'b0, 1'b0, rg(), rg(), rg());
    chk("bp_level15", 64'(level), 64'(15));
    chk("bp_stall", 64'(stall), 64'(1));
    for (int i = 0; i < 24; i++) begin
      v = (exp_q.size() < DEPTH) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
      cycle(v, 1'($urandom_range(0, 1)), 1'(i % 2), 1'b0, rg(), rg(), rg());
    end
    repeat (20) idle(1'b1);

    // Overflow at level 14 with a same-cycle read; flag survives flush
    repeat (4) cycle(3'b111, 1'b0, 1'b0, 1'b0, rg(), rg(), rg());
    cycle(3'b011, 1'b0, 1'b0, 1'b0, rg(), rg(), rg());
    cycle(3'b111, 1'b1, 1'b1, 1'b0, rg(), rg(), rg());
    chk("ovf_level13", 64'(level), 64'(13));
    chk("ovf_set", 64'(overflow), 64'(1));
    do_flush();
    chk("ovf_after_flush", 64'(overflow), 64'(1));

    // Full FIFO: a single gene is dropped even with out_ready high
    repeat (5) cycle(3'b111, 1'b0, 1'b0, 1'b0, rg(), rg(), rg());
    cycle(3'b100, 1'b0, 1'b0, 1'b0, rg(), rg(), rg());
    chk("full_level", 64'(level), 64'(16));
    cycle(3'b001, 1'b0, 1'b1, 1'b0, rg(), rg(), rg());
    do_flush();

    // Simultaneous read and write, then protocol error
    cycle(3'b001, 1'b0, 1'b0, 1'b0, rg(), rg(), rg());
    cycle(3'b011, 1'b0, 1'b1, 1'b0, rg(), rg(), rg());
    chk("rw_level2", 64'(level), 64'(2));
    cycle(3'b000, 1'b1, 1'b0, 1'b0, rg(), rg(), rg());
    chk("perr_set", 64'(proto_err), 64'(1));
    idle(1'b1);
    idle(1'b1);

    // Async reset in the middle of a drain
    cycle(3'b111, 1'b0, 1'b0, 1'b0, rg(), rg(), rg());
    cycle(3'b111, 1'b1, 1'b0, 1'b0, rg(), rg(), rg());
    chk("mid_level6", 64'(level), 64'(6));
    idle(1'b1);
    #2;
    rst = 1'b0;
    exp_q.delete();
    ovf_m = 1'b0;
    perr_m = 1'b0;
    #1;
    check_reset_outputs("rst1");
    in_valid = '0; genome_done = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    g = rg();
    cycle(3'b001, 1'b1, 1'b0, 1'b0, g, rg(), rg());
    chk("post_rst_gene", gene_out, g);

    // Random traffic respecting stall: flags must stay clear
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_flush();
      end else begin
        v = ((DEPTH - exp_q.size()) < 3) ? 3'b000 : 3'($urandom_range(0, 7));
        cycle(v, (v != 3'b000) && ($urandom_range(0, 3) == 0),
              $urandom_range(0, 9) < 7, 1'b0, rg(), rg(), rg());
      end
    end

    // Random traffic ignoring stall: drops and protocol errors occur
    for (int i = 0; i < 800; i++) begin
      cycle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0),
            $urandom_range(0, 9) < 4, 1'b0, rg(), rg(), rg());
    end
    repeat (20) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
